// File: rtl/branch_predictor_unit_pkg.sv
// rtl/branch_predictor_unit_pkg.sv - shared types, sizes and counter-update helper for the branch predictor
// Optional feature macro used by the design: BRANCH_PRED_GSHARE_EN (global history XOR indexing).
package branch_predictor_unit_pkg;

    localparam int BP_ADDR_WIDTH = 16;
    localparam int BP_INDEX_BITS = 6;
    localparam int BP_CNT_WIDTH  = 32;

    typedef enum logic {
        NOT_TAKEN = 1'b0,
        TAKEN     = 1'b1
    } BranchOutcome;

    // MSB of the state is the prediction.
    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } BhtState;

    // Saturating 2-bit counter step.
    function automatic BhtState bht_next(BhtState s, BranchOutcome o);
        BhtState n;
        n = s;
        case (s)
            STRONG_NT: n = (o == TAKEN) ? WEAK_NT  : STRONG_NT;
            WEAK_NT:   n = (o == TAKEN) ? WEAK_T   : STRONG_NT;
            WEAK_T:    n = (o == TAKEN) ? STRONG_T : WEAK_NT;
            STRONG_T:  n = (o == TAKEN) ? STRONG_T : WEAK_T;
            default:   n = s;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/branch_predictor_unit_if.sv
// rtl/branch_predictor_unit_if.sv - decode/EX signal bundle between pipeline glue and the branch predictor
// master: pipeline side (drives decode and EX inputs, receives prediction/redirect)
// slave : predictor side
interface branch_predictor_unit_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int INDEX_BITS = 6,
    parameter int CNT_WIDTH  = 32
);
    logic                  i_dec_valid;
    logic                  i_dec_is_jump;
    logic [ADDR_WIDTH-1:0] i_dec_pc;
    logic [ADDR_WIDTH-1:0] i_dec_target;
    logic [ADDR_WIDTH-1:0] i_dec_fallthrough;
    logic                  o_dec_prediction;
    logic [ADDR_WIDTH-1:0] o_dec_recovery;
    logic [INDEX_BITS-1:0] o_dec_index;

    logic                  i_ex_valid;
    logic                  i_ex_stall;
    logic [INDEX_BITS-1:0] i_ex_index;
    logic                  i_ex_prediction;
    logic                  i_ex_outcome;
    logic [ADDR_WIDTH-1:0] i_ex_recovery;
    logic                  o_redirect;
    logic [ADDR_WIDTH-1:0] o_redirect_target;
    logic [CNT_WIDTH-1:0]  o_mispredict_cnt;

    modport master (
        output i_dec_valid, i_dec_is_jump, i_dec_pc, i_dec_target, i_dec_fallthrough,
        output i_ex_valid, i_ex_stall, i_ex_index, i_ex_prediction, i_ex_outcome, i_ex_recovery,
        input  o_dec_prediction, o_dec_recovery, o_dec_index,
        input  o_redirect, o_redirect_target, o_mispredict_cnt
    );

    modport slave (
        input  i_dec_valid, i_dec_is_jump, i_dec_pc, i_dec_target, i_dec_fallthrough,
        input  i_ex_valid, i_ex_stall, i_ex_index, i_ex_prediction, i_ex_outcome, i_ex_recovery,
        output o_dec_prediction, o_dec_recovery, o_dec_index,
        output o_redirect, o_redirect_target, o_mispredict_cnt
    );
endinterface

// File: rtl/branch_predictor_unit_sat_counter_table.sv
// rtl/branch_predictor_unit_sat_counter_table.sv - 2^INDEX_BITS x 2-bit saturating counter table
// Ports: clk, rst_n (sync active-low, all entries -> WEAK_NT), raddr/rdata (async read),
//        we/waddr/wtaken (sync read-modify-write training port).
module sat_counter_table
    import branch_predictor_unit_pkg::*;
#(
    parameter int INDEX_BITS = BP_INDEX_BITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [INDEX_BITS-1:0] raddr,
    output BhtState               rdata,
    input  logic                  we,
    input  logic [INDEX_BITS-1:0] waddr,
    input  BranchOutcome          wtaken
);
    localparam int ENTRIES = 1 << INDEX_BITS;

    BhtState mem [ENTRIES];

    // The write port applies the counter step to its own entry, so training
    // never needs a second read port. The read port sees the pre-write value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                mem[i] <= WEAK_NT;
            end
        end else if (we) begin
            mem[waddr] <= bht_next(mem[waddr], wtaken);
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/branch_predictor_unit.sv
// rtl/branch_predictor_unit.sv - 2-bit counter branch predictor with EX-stage training and redirect
// Ports: clk, rst_n (sync active-low), bus (branch_predictor_unit_if.slave: decode lookup,
//        EX resolution, redirect and mispredict counter).
// Macro BRANCH_PRED_GSHARE_EN: adds a global history register XORed into the decode index.
module branch_predictor_unit
    import branch_predictor_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = BP_ADDR_WIDTH,
    parameter int INDEX_BITS = BP_INDEX_BITS,
    parameter int CNT_WIDTH  = BP_CNT_WIDTH
) (
    input logic                   clk,
    input logic                   rst_n,
    branch_predictor_unit_if.slave bus
);
    logic [INDEX_BITS-1:0] pc_index;
    logic [INDEX_BITS-1:0] dec_index;
    BhtState               dec_state;
    logic [1:0]            dec_bits;
    BranchOutcome          prediction;
    logic                  update;
    logic                  mispredict;
    logic [CNT_WIDTH-1:0]  mispredict_cnt;
    logic                  unused_pc_bits;

    assign pc_index       = bus.i_dec_pc[INDEX_BITS+1:2];
    assign unused_pc_bits = ^{bus.i_dec_pc[ADDR_WIDTH-1:INDEX_BITS+2], bus.i_dec_pc[1:0]};

    // A stalled EX stage holds the same branch; train only on the cycle it leaves.
    assign update     = bus.i_ex_valid & ~bus.i_ex_stall;
    assign mispredict = bus.i_ex_prediction != bus.i_ex_outcome;

`ifdef BRANCH_PRED_GSHARE_EN
    logic [INDEX_BITS-1:0] ghr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ghr <= '0;
        end else if (update) begin
            ghr <= {ghr[INDEX_BITS-2:0], bus.i_ex_outcome};
        end
    end

    assign dec_index = pc_index ^ ghr;
`else
    assign dec_index = pc_index;
`endif

    // EX trains the index that travelled down the pipe, never a recomputed one,
    // so history changes since decode cannot misdirect the update.
    sat_counter_table #(
        .INDEX_BITS(INDEX_BITS)
    ) u_table (
        .clk    (clk),
        .rst_n  (rst_n),
        .raddr  (dec_index),
        .rdata  (dec_state),
        .we     (update),
        .waddr  (bus.i_ex_index),
        .wtaken (BranchOutcome'(bus.i_ex_outcome))
    );

    assign dec_bits = dec_state;

    always_comb begin
        prediction = NOT_TAKEN;
        if (bus.i_dec_valid) begin
            if (bus.i_dec_is_jump) begin
                prediction = TAKEN;
            end else begin
                prediction = BranchOutcome'(dec_bits[1]);
            end
        end
    end

    assign bus.o_dec_prediction = prediction;
    assign bus.o_dec_index      = dec_index;
    assign bus.o_dec_recovery   = (!bus.i_dec_valid || prediction == TAKEN) ?
                                  bus.i_dec_fallthrough : bus.i_dec_target;

    // Held for the whole stall; the hazard controller is responsible for flushing once.
    assign bus.o_redirect        = rst_n & bus.i_ex_valid & mispredict;
    assign bus.o_redirect_target = bus.i_ex_recovery;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mispredict_cnt <= '0;
        end else if (update && mispredict && (mispredict_cnt != {CNT_WIDTH{1'b1}})) begin
            mispredict_cnt <= mispredict_cnt + 1'b1;
        end
    end

    assign bus.o_mispredict_cnt = mispredict_cnt;

endmodule

// File: tb/tb_branch_predictor_unit.sv
// tb/tb_branch_predictor_unit.sv - self-checking bench for branch_predictor_unit
module tb_branch_predictor_unit;
    localparam int AW = 16;
    localparam int IB = 6;
    localparam int CW = 32;
    localparam int N  = 1 << IB;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    branch_predictor_unit_if #(.ADDR_WIDTH(AW), .INDEX_BITS(IB), .CNT_WIDTH(CW)) bus ();

    branch_predictor_unit #(.ADDR_WIDTH(AW), .INDEX_BITS(IB), .CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: counters as integers 0..3, prediction taken when >= 2.
    int          bht [N];
    longint      mcnt;
    int          ghr;
    bit          model_valid = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_index(input logic [AW-1:0] pc);
        return ((int'(pc) >> 2) % N) ^ ghr;
    endfunction

    function automatic int model_pred(input logic [AW-1:0] pc, input bit valid, input bit jump);
        if (!valid) return 0;
        if (jump) return 1;
        return (bht[model_index(pc)] >= 2) ? 1 : 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) bht[i] = 1;
        mcnt = 0;
        ghr = 0;
        model_valid = 1'b1;
    endtask

    task automatic model_train(input int idx, input bit pred, input bit outc);
        if (outc) bht[idx] = (bht[idx] == 3) ? 3 : bht[idx] + 1;
        else      bht[idx] = (bht[idx] == 0) ? 0 : bht[idx] - 1;
        if (pred != outc && mcnt != 64'hFFFF_FFFF) mcnt = mcnt + 1;
`ifdef BRANCH_PRED_GSHARE_EN
        ghr = ((ghr << 1) | int'(outc)) % N;
`endif
    endtask

    task automatic drive_dec(input bit v, input bit j, input logic [AW-1:0] pc,
                             input logic [AW-1:0] tgt, input logic [AW-1:0] ft);
        bus.i_dec_valid = v;
        bus.i_dec_is_jump = j;
        bus.i_dec_pc = pc;
        bus.i_dec_target = tgt;
        bus.i_dec_fallthrough = ft;
    endtask

    task automatic drive_ex(input bit v, input bit s, input logic [IB-1:0] idx,
                            input bit p, input bit o, input logic [AW-1:0] rec);
        bus.i_ex_valid = v;
        bus.i_ex_stall = s;
        bus.i_ex_index = idx;
        bus.i_ex_prediction = p;
        bus.i_ex_outcome = o;
        bus.i_ex_recovery = rec;
    endtask

    // Check all outputs against the model, then take one clock edge and advance the model.
    task automatic cycle(input string tag);
        int  ep;
        #1;
        check({tag, ":redirect"}, bus.o_redirect,
              rst_n & bus.i_ex_valid & (bus.i_ex_prediction != bus.i_ex_outcome));
        check({tag, ":redirect_target"}, bus.o_redirect_target, bus.i_ex_recovery);
        if (model_valid) begin
            ep = model_pred(bus.i_dec_pc, bus.i_dec_valid, bus.i_dec_is_jump);
            check({tag, ":pred"}, bus.o_dec_prediction, ep);
            check({tag, ":recovery"}, bus.o_dec_recovery,
                  (!bus.i_dec_valid || ep == 1) ? bus.i_dec_fallthrough : bus.i_dec_target);
            check({tag, ":index"}, bus.o_dec_index, model_index(bus.i_dec_pc));
            check({tag, ":cnt"}, bus.o_mispredict_cnt, mcnt);
        end
        @(posedge clk);
        if (!rst_n) model_reset();
        else if (model_valid && bus.i_ex_valid && !bus.i_ex_stall)
            model_train(int'(bus.i_ex_index), bus.i_ex_prediction, bus.i_ex_outcome);
        #1;
    endtask

    longint c0;

    initial begin
        // Reset with a mispredicting EX input present: redirect must stay low.
        drive_dec(1'b0, 1'b0, '0, '0, '0);
        drive_ex(1'b1, 1'b0, 6'd3, 1'b0, 1'b1, 16'h0AAA);
        rst_n = 1'b0;
        cycle("reset0");
        cycle("reset1");
        rst_n = 1'b1;
        drive_ex(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
        cycle("post_reset");
        check("reset_cnt_zero", bus.o_mispredict_cnt, 0);
        check("idle_pred_nt", bus.o_dec_prediction, 0);

        // First lookup after reset: weakly not-taken, recovery = taken target.
        drive_dec(1'b1, 1'b0, 16'h0040, 16'h0100, 16'h0044);
        #1;
        check("pc40_index", bus.o_dec_index, 6'h10);
        check("pc40_pred_nt", bus.o_dec_prediction, 0);
        check("pc40_recovery", bus.o_dec_recovery, 16'h0100);
        cycle("pc40");

        // Two taken updates at index 0x10 flip the prediction.
        for (int k = 0; k < 2; k++) begin
            drive_ex(1'b1, 1'b0, 6'h10, 1'(bht[16] >= 2), 1'b1, 16'h0044);
            cycle("train_t");
        end
        drive_ex(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
        #1;
`ifndef BRANCH_PRED_GSHARE_EN
        check("pc40_pred_t", bus.o_dec_prediction, 1);
        check("pc40_recovery_t", bus.o_dec_recovery, 16'h0044);
`endif
        cycle("pc40_after");
        // Third taken saturates: one not-taken still predicts taken, a second does not.
        drive_ex(1'b1, 1'b0, 6'h10, 1'b1, 1'b1, '0);
        cycle("train_t3");
        drive_ex(1'b1, 1'b0, 6'h10, 1'b1, 1'b0, '0);
        cycle("train_nt1");
        drive_ex(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
        drive_dec(1'b1, 1'b0, 16'h0040, 16'h0100, 16'h0044);
        #1;
`ifndef BRANCH_PRED_GSHARE_EN
        check("sat_after_nt1", bus.o_dec_prediction, 1);
`endif
        drive_ex(1'b1, 1'b0, 6'h10, 1'b1, 1'b0, '0);
        cycle("train_nt2");
        drive_ex(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
        #1;
`ifndef BRANCH_PRED_GSHARE_EN
        check("sat_after_nt2", bus.o_dec_prediction, 0);
`endif
        cycle("sat_done");

        // Mispredict held through a 3-cycle stall counts once.
        c0 = mcnt;
        drive_ex(1'b1, 1'b1, 6'h20, 1'b0, 1'b1, 16'h0120);
        for (int k = 0; k < 3; k++) begin
            #1;
            check("stall_redirect", bus.o_redirect, 1);
            check("stall_target", bus.o_redirect_target, 16'h0120);
            check("stall_cnt_hold", bus.o_mispredict_cnt, c0);
            cycle("stall");
        end
        bus.i_ex_stall = 1'b0;
        cycle("stall_release");
        drive_ex(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
        #1;
        check("stall_cnt_plus1", bus.o_mispredict_cnt, c0 + 1);
        check("redirect_clear", bus.o_redirect, 0);
        cycle("stall_done");

        // Same-index collision: decode sees the pre-update counter.
        drive_dec(1'b1, 1'b0, 16'h0014, 16'h0200, 16'h0018);
        drive_ex(1'b1, 1'b0, 6'd5, 1'b0, 1'b1, 16'h0200);
        #1;
`ifndef BRANCH_PRED_GSHARE_EN
        check("collide_old", bus.o_dec_prediction, 0);
`endif
        cycle("collide");
        drive_ex(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
        #1;
`ifndef BRANCH_PRED_GSHARE_EN
        check("collide_new", bus.o_dec_prediction, 1);
`endif
        cycle("collide_after");

        // Jump: predicted taken, recovery = fallthrough, table untouched.
        drive_dec(1'b1, 1'b1, 16'h000C, 16'h0300, 16'h0010);
        #1;
        check("jump_pred", bus.o_dec_prediction, 1);
        check("jump_recovery", bus.o_dec_recovery, 16'h0010);
        cycle("jump");
        bus.i_dec_is_jump = 1'b0;
        #1;
`ifndef BRANCH_PRED_GSHARE_EN
        check("jump_no_train", bus.o_dec_prediction, 0);
`endif
        cycle("jump_after");

        // Randomised traffic on a small index set to force collisions and saturation.
        for (int k = 0; k < 400; k++) begin
            logic [AW-1:0] pc;
            pc = {8'($urandom), 3'b000, 3'($urandom_range(0, 7)), 2'($urandom)};
            drive_dec(1'($urandom), 1'($urandom_range(0, 7) == 0), pc, 16'($urandom), 16'($urandom));
            drive_ex(1'($urandom), 1'($urandom_range(0, 3) == 0), 6'($urandom_range(0, 7)),
                     1'($urandom), 1'($urandom), 16'($urandom));
            cycle("rand");
        end

        // Reset in the middle of a stalled mispredict drops the update.
        drive_ex(1'b1, 1'b1, 6'd2, 1'b1, 1'b0, 16'h0400);
        cycle("pre_rst_stall");
        rst_n = 1'b0;
        cycle("rst_mid_stall");
        rst_n = 1'b1;
        bus.i_ex_stall = 1'b0;
        bus.i_ex_valid = 1'b0;
        drive_dec(1'b1, 1'b0, 16'h0008, 16'h0500, 16'h000C);
        #1;
        check("rst_stall_cnt", bus.o_mispredict_cnt, 0);
        check("rst_stall_pred", bus.o_dec_prediction, 0);
        cycle("rst_stall_after");

`ifdef BRANCH_PRED_GSHARE_EN
        // History T,T,NT -> 0b110; pc index 7 maps to 7 ^ 6 = 1.
        drive_ex(1'b1, 1'b0, 6'd9, 1'b0, 1'b1, '0);
        cycle("ghr_t1");
        cycle("ghr_t2");
        bus.i_ex_outcome = 1'b0;
        cycle("ghr_nt");
        drive_ex(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
        drive_dec(1'b1, 1'b0, 16'h001C, 16'h0600, 16'h0020);
        #1;
        check("gshare_index", bus.o_dec_index, 6'h01);
        cycle("gshare_after");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
